// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity mode codes, transmit FSM states, frame-length helper.
package usrt_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Bit periods per frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_width, input int stop_bits, input logic par_en);
    return 1 + data_width + (par_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/usrt_tx_framer_if.sv
// Host-side handshake and line signals of the USRT transmit framer.
// With USRT_TX_BREAK_EN defined the interface also carries i_Break.
interface usrt_tx_framer_if #(parameter int DATA_WIDTH = 8);

  logic                  i_BitEn;
  logic                  i_Valid;
  logic [DATA_WIDTH-1:0] i_Data;
  logic [1:0]            i_Parity;
  logic                  o_Ready;
  logic                  o_Tx;
  logic                  o_Busy;
  logic                  o_Done;
`ifdef USRT_TX_BREAK_EN
  logic                  i_Break;

  modport master (output i_BitEn, i_Valid, i_Data, i_Parity, i_Break,
                  input  o_Ready, o_Tx, o_Busy, o_Done);
  modport slave  (input  i_BitEn, i_Valid, i_Data, i_Parity, i_Break,
                  output o_Ready, o_Tx, o_Busy, o_Done);
`else
  modport master (output i_BitEn, i_Valid, i_Data, i_Parity,
                  input  o_Ready, o_Tx, o_Busy, o_Done);
  modport slave  (input  i_BitEn, i_Valid, i_Data, i_Parity,
                  output o_Ready, o_Tx, o_Busy, o_Done);
`endif

endinterface

// File: rtl/usrt_parity_gen.sv
// Combinational parity bit for a USRT word; shared by transmit and receive paths.
module usrt_parity_gen
  import usrt_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            mode,
  output logic                  par_bit,
  output logic                  par_en
);

  assign par_bit = (^data) ^ (mode == PAR_ODD);
  assign par_en  = (mode == PAR_ODD) || (mode == PAR_EVEN);

endmodule

// File: rtl/usrt_tx_framer.sv
// USRT transmit framer: start, data LSB first, optional parity, stop bits on o_Tx.
// Optional line break generation is built when USRT_TX_BREAK_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a word (or holding/recovering from break)
// START  | start bit (low) on the line
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), high; last one may re-accept back-to-back
module usrt_tx_framer
  import usrt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic           i_Pclk,
  input  logic           i_Rst_n,
  usrt_tx_framer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  tx_q, tx_nxt;
  logic                  busy_q;
  logic                  par_bit_q, par_bit_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  gen_bit, gen_en;
  logic                  last_stop, ready, accept;
  logic                  brk_hold, idle_ok;

  usrt_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity_gen (
    .data    (bus.i_Data),
    .mode    (bus.i_Parity),
    .par_bit (gen_bit),
    .par_en  (gen_en)
  );

`ifdef USRT_TX_BREAK_EN
  logic             brk_act, brk_act_nxt;
  logic [CNT_W-1:0] brk_cnt, brk_cnt_nxt;
  assign brk_hold = bus.i_Break;
  assign idle_ok  = !bus.i_Break && !brk_act;
`else
  assign brk_hold = 1'b0;
  assign idle_ok  = 1'b1;
`endif

  assign last_stop = (state == STOP) && (cnt == '0);
  // A break request mid-frame blocks the back-to-back re-accept so the line can go low.
  assign ready     = ((state == IDLE) && idle_ok) || (last_stop && bus.i_BitEn && !brk_hold);
  assign accept    = bus.i_Valid && ready;

  assign bus.o_Ready = ready;
  assign bus.o_Done  = last_stop && bus.i_BitEn;
  assign bus.o_Tx    = tx_q;
  assign bus.o_Busy  = busy_q;

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`ifdef USRT_TX_BREAK_EN
      brk_act   <= 1'b0;
      brk_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      tx_q      <= tx_nxt;
      busy_q    <= (state_nxt != IDLE);
      par_bit_q <= par_bit_nxt;
      par_en_q  <= par_en_nxt;
`ifdef USRT_TX_BREAK_EN
      brk_act   <= brk_act_nxt;
      brk_cnt   <= brk_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    tx_nxt      = tx_q;
    par_bit_nxt = par_bit_q;
    par_en_nxt  = par_en_q;
`ifdef USRT_TX_BREAK_EN
    brk_act_nxt = brk_act;
    brk_cnt_nxt = brk_cnt;
`endif

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
`ifdef USRT_TX_BREAK_EN
        if (bus.i_Break) begin
          tx_nxt      = 1'b0;
          brk_act_nxt = 1'b1;
          brk_cnt_nxt = STOP_LAST;
        end else if (brk_act && bus.i_BitEn) begin
          if (brk_cnt == '0) brk_act_nxt = 1'b0;
          else               brk_cnt_nxt = brk_cnt - 1'b1;
        end
`endif
      end
      START: begin
        if (bus.i_BitEn) begin
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = DATA_LAST;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.i_BitEn) begin
          if (cnt != '0) begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt - 1'b1;
          end else if (par_en_q) begin
            tx_nxt    = par_bit_q;
            state_nxt = PARITY;
          end else begin
            tx_nxt    = 1'b1;
            cnt_nxt   = STOP_LAST;
            state_nxt = STOP;
          end
        end
      end
      PARITY: begin
        if (bus.i_BitEn) begin
          tx_nxt    = 1'b1;
          cnt_nxt   = STOP_LAST;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bus.i_BitEn) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase

    // Accept overrides the per-state update: from IDLE or from the final stop strobe.
    if (accept) begin
      state_nxt   = START;
      tx_nxt      = 1'b0;
      shreg_nxt   = bus.i_Data;
      cnt_nxt     = '0;
      par_bit_nxt = gen_bit;
      par_en_nxt  = gen_en;
    end
  end

endmodule

// File: doc/usrt_tx_framer.md
Name: usrt_tx_framer

Overview:
Parametrised USRT transmit framer and serializer. It accepts a parallel word through a valid/ready handshake and computes the selected parity. It then shifts out start, data (LSB first), optional parity and stop bits on o_Tx, one bit per i_BitEn strobe of the shared USRT bit clock. It sits between the host-side transmit register and the USRT line driver, and replaces the fixed 8-bit combinational parity framer.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
i_Pclk  in  1  USRT bit clock; all state updates on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_BitEn  in  1  bit-advance strobe; tie high for one bit per i_Pclk cycle
i_Valid  in  1  host presents a word
i_Data  in  DATA_WIDTH  word to send
i_Parity  in  2  00 none, 01 odd, 10 even, 11 none (reserved)
o_Ready  out  1  framer can accept a word this cycle
o_Tx  out  1  serial line, registered, idle high
o_Busy  out  1  frame in progress
o_Done  out  1  one-cycle pulse at the end of the final stop bit

Behaviour:
- Reset (async assert, sync release): state IDLE, o_Tx=1, o_Busy=0, o_Done=0, shift/count registers cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept occurs on a rising edge with i_Valid & o_Ready. i_Data and i_Parity are latched together; later changes are ignored until the next accept.
- Accept does not require i_BitEn.
- o_Ready is combinational. It is 1 in IDLE, and 1 in the last STOP bit while i_BitEn=1. Otherwise it is 0.
- On accept:
  - state=START and o_Tx<=0 on the same edge.
  - Parity bit = XOR of data bits, inverted for odd.
- Advance happens only on edges with i_BitEn=1. Each bit is therefore held until the next strobe.
  - START -> DATA: o_Tx<=data[0].
  - DATA: shifts out data[1..DATA_WIDTH-1]. After the last data bit, go to PARITY (mode 01/10) or STOP (mode 00/11).
  - PARITY -> STOP: o_Tx<=1.
  - STOP lasts STOP_BITS strobes.
- End of last stop bit (edge with i_BitEn=1 in the last STOP bit):
  - o_Done=1 for one cycle.
  - With i_Valid=1: re-accept and go directly to START (o_Tx<=0). There is no idle gap between frames.
  - With i_Valid=0: go to IDLE with o_Tx=1.
- Frame length in bit periods = 1 + DATA_WIDTH + (parity?1:0) + STOP_BITS.
- o_Busy = (state != IDLE), registered.
- i_BitEn=0 freezes all state and o_Tx. The strobe is not accumulated.
- Reset mid-frame: line returns to 1 immediately and the partial frame is discarded. No o_Done.

Optional Feature:
Macro USRT_TX_BREAK_EN.
- Defined: adds input i_Break (1 bit).
  - While i_Break=1 in IDLE, o_Tx=0 and o_Ready=0.
  - i_Break asserted mid-frame takes effect after that frame's o_Done.
  - On deassert, o_Tx=1 for STOP_BITS strobes before o_Ready returns to 1.
- Undefined: the port is absent and the line is never held low outside START/data/parity bits.

Decomposition:
- Shared package usrt_pkg holds:
  - the parity mode constants (PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_RSVD=2'b11);
  - the FSM state typedef;
  - the frame-length helper function.
- One natural sub-module: usrt_parity_gen, a combinational parity bit from data and mode. The receive side reuses it.

Test Plan:
- DATA_WIDTH=8, STOP_BITS=1, i_BitEn=1, i_Parity=01, i_Data=8'h03 -> o_Tx sequence 0,1,1,0,0,0,0,0,0,1,1 (parity 1); o_Done pulses on cycle 11; o_Busy high for 11 cycles.
- i_Parity=10, i_Data=8'h07 -> 0,1,1,1,0,0,0,0,0,1,1 (parity 1). Then i_Parity=10, i_Data=8'h03 -> parity bit 0.
- i_Valid held with two words (8'hA5, 8'h3C), parity 00 -> 20 contiguous bits with no idle gap. o_Ready is high exactly in the last stop cycle; two o_Done pulses.
- i_BitEn high every 4th cycle, 8'h55, parity 00 -> each bit held exactly 4 cycles. Changing i_Data/i_Parity mid-frame does not affect output.
- i_Rst_n low during data bit 3 -> o_Tx=1 and o_Busy=0 immediately, no o_Done. After release, o_Ready=1 and the next frame is sent cleanly.
- STOP_BITS=2, DATA_WIDTH=5, parity 01, 5'b10110 -> 0,0,1,1,0,1,0,1,1 (9 bits). Under USRT_TX_BREAK_EN, i_Break for 10 cycles -> o_Tx=0 for those cycles, then 2 high bits before o_Ready rises.
